// File: rtl/intr_ctrl_multi.sv
// Multi-channel interrupt controller: per-line synchroniser, edge/level pending capture,
// fixed-priority delivery strobe gated by the D-stage slot. Optional glitch filter: INTR_CTRL_FILTER_EN.
module intr_ctrl_multi #(
    parameter int NUM_INTR    = 4,
    parameter int ID_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_CNT  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_INTR-1:0] intr,
    input  logic [NUM_INTR-1:0] intr_mode,
    input  logic [NUM_INTR-1:0] intr_mask,
    input  logic                ifu_exu_vld_d,
    input  logic                intr_ack,
    output logic                intr_pulse,
    output logic [ID_W-1:0]     intr_id,
    output logic [NUM_INTR-1:0] intr_pending,
    output logic                intr_busy
);

    typedef enum logic {IDLE = 1'b0, INSVC = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [NUM_INTR-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INTR-1:0] sync_d [SYNC_STAGES];
    logic [NUM_INTR-1:0] s, f;
    logic [NUM_INTR-1:0] f_prev_q, f_prev_d;
    logic [NUM_INTR-1:0] pending_q, pending_d;
    logic [NUM_INTR-1:0] req, rise, sel_oh, deliver_oh;
    logic [ID_W-1:0]     sel_id;

    always_comb begin
        sync_d[0] = intr;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef INTR_CTRL_FILTER_EN
    localparam int CNT_W = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;

    logic [NUM_INTR-1:0] filt_q, filt_d;
    logic [CNT_W-1:0]    cnt_q [NUM_INTR];
    logic [CNT_W-1:0]    cnt_d [NUM_INTR];

    // The filtered level flips only after FILTER_CNT consecutive disagreeing samples.
    always_comb begin
        for (int i = 0; i < NUM_INTR; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (s[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(FILTER_CNT - 1)) begin
                    filt_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < NUM_INTR; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < NUM_INTR; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign f = filt_q;
`else
    assign f = s;
`endif

    assign rise     = f & ~f_prev_q;
    assign f_prev_d = f;
    assign req      = pending_q & intr_mask;

    // Walk downward so the lowest set index wins.
    always_comb begin
        sel_id = '0;
        sel_oh = '0;
        for (int i = NUM_INTR - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel_id    = ID_W'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Edge channels: a fresh rise beats a same-cycle delivery clear. Level channels track f.
    always_comb begin
        for (int i = 0; i < NUM_INTR; i++) begin
            if (intr_mode[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~deliver_oh[i]);
            end else begin
                pending_d[i] = f[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            f_prev_q  <= '0;
            pending_q <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            f_prev_q  <= f_prev_d;
            pending_q <= pending_d;
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((|req) && ifu_exu_vld_d) state_d = INSVC;
            INSVC:   if (intr_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        intr_pulse = 1'b0;
        intr_id    = '0;
        intr_busy  = 1'b0;
        deliver_oh = '0;
        case (state_q)
            IDLE: begin
                if ((|req) && ifu_exu_vld_d) begin
                    intr_pulse = 1'b1;
                    intr_id    = sel_id;
                    deliver_oh = sel_oh;
                end
            end
            INSVC:   intr_busy = 1'b1;
            default: intr_busy = 1'b0;
        endcase
    end

    assign intr_pending = pending_q;

endmodule
